// File: rtl/program_loader.sv
// Streams address/count-framed program bytes from an upstream source into CPU memory while holding the CPU off.
// Optional trailing checksum byte per frame when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              frame_done,
  output logic              err,
  output logic [ADDR_W:0]   bytes_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA} state_t;
`endif

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   frame_len;
  logic [ADDR_W:0]   frame_idx;
  logic [ADDR_W:0]   idx_next;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign in_ready = load && (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign idx_next = frame_idx + CNT_ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      frame_len    <= '0;
      frame_idx    <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      cpu_hold     <= 1'b1;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      bytes_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      cpu_hold   <= load || (state != IDLE);
      case (state)
        IDLE: begin
          if (load) begin
            state <= ADDR;
            err   <= 1'b0;
          end
        end
        ADDR: begin
          if (!load) begin
            state <= IDLE;
          end else if (accept) begin
            base         <= in_data[ADDR_W-1:0];
            bytes_loaded <= '0;
            frame_idx    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
            state        <= COUNT;
          end
        end
        COUNT: begin
          if (!load) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            // A zero count means a full memory image: the extra top bit encodes 2**ADDR_W.
            frame_len <= {(in_data[ADDR_W-1:0] == '0), in_data[ADDR_W-1:0]};
            state     <= DATA;
          end
        end
        DATA: begin
          if (!load) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            mem_we       <= 1'b1;
            mem_addr     <= base + frame_idx[ADDR_W-1:0];
            mem_data     <= in_data;
            frame_idx    <= idx_next;
            bytes_loaded <= bytes_loaded + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
            sum          <= sum + in_data[7:0];
            if (idx_next == frame_len) state <= CHK;
`else
            if (idx_next == frame_len) begin
              state      <= ADDR;
              frame_done <= 1'b1;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (!load) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            if (in_data[7:0] == sum) frame_done <= 1'b1;
            else                     err        <= 1'b1;
            state <= ADDR;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, instruction/data memory address width (32 locations).
REQ-002 The block SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port load, input, 1, load-session enable driven alongside the CPU Load input.
REQ-006 The block SHALL have port in_valid, input, 1, upstream byte valid.
REQ-007 The block SHALL have port in_data, input, DATA_W, upstream byte.
REQ-008 The block SHALL have port in_ready, output, 1, byte accepted when in_valid and in_ready are both high on a clock edge.
REQ-009 The block SHALL have port mem_we, output, 1, memory write strobe to CPU memory.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W, memory write address.
REQ-011 The block SHALL have port mem_data, output, DATA_W, memory write data.
REQ-012 The block SHALL have port cpu_hold, output, 1, high while the CPU must not fetch.
REQ-013 The block SHALL have port frame_done, output, 1, one-cycle pulse on good frame completion.
REQ-014 The block SHALL have port err, output, 1, sticky error flag.
REQ-015 The block SHALL have port bytes_loaded, output, ADDR_W+1, data bytes written in the current frame.

Function
REQ-016 The block SHALL implement FSM states IDLE, ADDR, COUNT, DATA, and CHK (CHK only per REQ-031).
REQ-017 The block SHALL drive in_ready as a combinational signal equal to load AND (state is ADDR, COUNT, DATA or CHK); bytes presented while load is low are never accepted.
REQ-018 IDLE: the block SHALL go to ADDR on the edge where load=1, and SHALL clear err on that edge.
REQ-019 ADDR: on accept, the block SHALL set base=in_data[4:0], ignore bits 7:5, clear bytes_loaded and the frame index, and go to COUNT.
REQ-020 COUNT: on accept, the block SHALL set length=in_data[4:0], with 0 meaning 32 and bits 7:5 ignored, and go to DATA.
REQ-021 DATA: each accepted byte SHALL produce exactly one registered write one cycle later: mem_we=1, mem_addr=(base+index) mod 32, mem_data=byte; the block SHALL then increment index and bytes_loaded.
REQ-022 Address wrap: the address after 0x1F SHALL be 0x00; no error is raised on wrap.
REQ-023 On acceptance of the last data byte, the block SHALL go to CHK if enabled, otherwise return to ADDR and pulse frame_done in the following cycle, aligned with the final mem_we.
REQ-024 Back-to-back frames: the block SHALL allow any number of frames while load stays high, with no idle cycle required between them.
REQ-025 Gaps: the block SHALL tolerate in_valid low for any number of cycles in any state with no state change; the block SHALL emit no mem_we without an accepted byte.
REQ-026 Abort: if load is low while in COUNT, DATA or CHK, the block SHALL set err=1 and go to IDLE; writes already issued remain; no frame_done.
REQ-027 If load is low in ADDR, the block SHALL go to IDLE without an error.
REQ-028 The block SHALL register cpu_hold as load OR (state != IDLE), so cpu_hold falls one cycle after the FSM reaches IDLE.

Reset
REQ-029 While reset is low, the block SHALL asynchronously force state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, frame_done=0, err=0, bytes_loaded=0, with base, length and index at 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame silently; after release, the block SHALL stay in IDLE until load=1.

Configuration
REQ-031 When macro LOADER_CHECKSUM_EN is defined, the block SHALL accumulate an 8-bit running sum (mod 256) of the data bytes; CHK SHALL accept one trailing byte; on match the block SHALL pulse frame_done and return to ADDR; on mismatch it SHALL set err=1, pulse no frame_done, and return to ADDR. When the macro is undefined, the block SHALL have no CHK state and no accumulator, and err SHALL be set only by abort.

Verification
REQ-032 Bench: frame 0x00, 0x12, then 18 program bytes (LDA 0xBB ... JMP 0xE0); then frame 0x1A, 0x04, then 0x01, 0xAA, 0xFF, 0x00 -> 22 writes at 0x00-0x11 and 0x1A-0x1D with exact data, and two frame_done pulses.
REQ-033 Bench: frame 0x1E, 0x04, then A0, A1, A2, A3 -> writes at 0x1E, 0x1F, 0x00, 0x01; bytes_loaded=4.
REQ-034 Bench: random in_valid gaps of 0-5 cycles during REQ-032 -> identical write sequence, and no mem_we in gap cycles.
REQ-035 Bench: load dropped after 2 of 4 data bytes -> 2 writes, err=1, state IDLE, cpu_hold falls next cycle; next load rise clears err.
REQ-036 Bench: reset pulsed low mid-DATA -> all outputs at reset values immediately, no further writes.
REQ-037 Bench (LOADER_CHECKSUM_EN): frame 0x00, 0x02, 0x10, 0x20, then checksum 0x30 -> frame_done; checksum 0x31 -> err=1 and no frame_done.
